linebuf_ctrl: RTL and testbench

LINEBUF_CTRL -- requirements
Module: linebuf_ctrl

---
 rtl/linebuf_pkg.sv | 21 ++
 rtl/linebuf_rd_counter.sv | 31 +++
 rtl/linebuf_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_linebuf_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/linebuf_pkg.sv
// Shared types and constants for the line-buffer read/write controller.
// Four line slots are addressed by the top two bits of the 12-bit line-RAM address.
package linebuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
    localparam int PIX_W     = 10;
    localparam int ADDR_W    = 12;

    // Number of times each buffered line is read out: twice when line doubling.
    function automatic logic [1:0] passes_for(input logic doubler);
        return doubler ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/linebuf_rd_counter.sv
// Read-side pixel counter: synchronous clear, count enable, saturating at LINE_WIDTH-1.
module linebuf_rd_counter
    import linebuf_pkg::*;
#(
    parameter int LINE_WIDTH = 640
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [PIX_W-1:0] o_pixel
);

    localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(LINE_WIDTH - 1);

    logic [PIX_W-1:0] r_pixel;

    // Clear has priority so a line start in the same cycle as active video restarts at 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel <= '0;
        end else if (i_clear) begin
            r_pixel <= '0;
        end else if (i_enable && (r_pixel < PIX_MAX)) begin
            r_pixel <= r_pixel + 1'b1;
        end
    end

    assign o_pixel = r_pixel;

endmodule

// File: rtl/linebuf_ctrl.sv
// Line-buffer controller: primes a 4-slot line RAM from the capture side, then
// hands slots to the output timing once (480p) or twice (line doubling) each.
module linebuf_ctrl
    import linebuf_pkg::*;
#(
    parameter int LINE_WIDTH  = 640,
    parameter int PRIME_LINES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              line_doubler,
    input  logic              starttrigger,
    input  logic              wr_line_done,
    input  logic              rd_line_start,
    input  logic              rd_active,
    output logic [ADDR_W-1:0] rdaddr,
    output logic [SLOT_W-1:0] wr_slot,
    output logic [2:0]        fill,
    output logic              running,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [2:0] FILL_MAX   = 3'(NUM_SLOTS);
    localparam logic [2:0] PRIME_FILL = 3'(PRIME_LINES);

    state_t            r_state;
    logic [2:0]        r_fill;
    logic [SLOT_W-1:0] r_wr_slot;
    logic [SLOT_W-1:0] r_rd_slot;
    logic              r_pass_cnt;
    logic              r_holding;
    logic              r_ld;
    logic              r_running;
    logic              r_overflow;
    logic              r_underflow;

    state_t            w_state_nxt;
    logic [2:0]        w_fill_nxt;
    logic [SLOT_W-1:0] w_wr_slot_nxt;
    logic [SLOT_W-1:0] w_rd_slot_nxt;
    logic              w_pass_cnt_nxt;
    logic              w_holding_nxt;
    logic              w_overflow_nxt;
    logic              w_underflow_nxt;
    logic              w_pix_clear;
    logic              w_pix_en;
    logic              w_release;
    logic              w_wr_ok;
    logic [2:0]        w_fill_rel;
    logic [1:0]        w_passes;
    logic              w_more_pass;
    logic [PIX_W-1:0]  w_pixel;

    assign w_passes    = passes_for(r_ld);
    assign w_more_pass = ({1'b0, r_pass_cnt} < (w_passes - 2'd1));

    // A release and a write in the same cycle net out, so fill is computed
    // as (fill minus release) plus accepted write.
    always_comb begin
        w_state_nxt     = r_state;
        w_fill_nxt      = r_fill;
        w_wr_slot_nxt   = r_wr_slot;
        w_rd_slot_nxt   = r_rd_slot;
        w_pass_cnt_nxt  = r_pass_cnt;
        w_holding_nxt   = r_holding;
        w_overflow_nxt  = 1'b0;
        w_underflow_nxt = 1'b0;
        w_pix_clear     = 1'b0;
        w_pix_en        = 1'b0;
        w_release       = 1'b0;
        w_wr_ok         = 1'b0;
        w_fill_rel      = r_fill;

        case (r_state)
            ST_IDLE: begin
                if (starttrigger) begin
                    w_state_nxt    = ST_PRIME;
                    w_fill_nxt     = '0;
                    w_wr_slot_nxt  = '0;
                    w_rd_slot_nxt  = '0;
                    w_pass_cnt_nxt = 1'b0;
                    w_holding_nxt  = 1'b0;
                    w_pix_clear    = 1'b1;
                end
            end

            ST_PRIME: begin
                if (wr_line_done && (r_fill < FILL_MAX)) begin
                    w_fill_nxt    = r_fill + 3'd1;
                    w_wr_slot_nxt = r_wr_slot + 1'b1;
                end
                if (r_fill >= PRIME_FILL) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                w_pix_en = rd_active;
                if (rd_line_start) begin
                    w_pix_clear = 1'b1;
                    if (r_holding && w_more_pass) begin
                        w_pass_cnt_nxt = r_pass_cnt + 1'b1;
                    end else begin
                        if (r_holding) begin
                            w_release     = 1'b1;
                            w_fill_rel    = r_fill - 3'd1;
                            w_rd_slot_nxt = r_rd_slot + 1'b1;
                        end
                        if (w_fill_rel != 3'd0) begin
                            w_holding_nxt  = 1'b1;
                            w_pass_cnt_nxt = 1'b0;
                        end else begin
                            w_underflow_nxt = 1'b1;
                            w_holding_nxt   = 1'b0;
                        end
                    end
                end
                // A full buffer with no release drops the write; capture keeps the same slot.
                if (wr_line_done) begin
                    if ((r_fill == FILL_MAX) && !w_release) begin
                        w_overflow_nxt = 1'b1;
                    end else begin
                        w_wr_ok       = 1'b1;
                        w_wr_slot_nxt = r_wr_slot + 1'b1;
                    end
                end
                w_fill_nxt = w_fill_rel + {2'b00, w_wr_ok};
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (line_doubler != r_ld) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_fill      <= '0;
            r_wr_slot   <= '0;
            r_rd_slot   <= '0;
            r_pass_cnt  <= 1'b0;
            r_holding   <= 1'b0;
            r_ld        <= 1'b0;
            r_running   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill      <= w_fill_nxt;
            r_wr_slot   <= w_wr_slot_nxt;
            r_rd_slot   <= w_rd_slot_nxt;
            r_pass_cnt  <= w_pass_cnt_nxt;
            r_holding   <= w_holding_nxt;
            r_ld        <= line_doubler;
            r_running   <= (w_state_nxt == ST_RUN);
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    linebuf_rd_counter #(
        .LINE_WIDTH (LINE_WIDTH)
    ) u_rd_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_clear  (w_pix_clear),
        .i_enable (w_pix_en),
        .o_pixel  (w_pixel)
    );

    assign rdaddr    = {r_rd_slot, w_pixel};
    assign wr_slot   = r_wr_slot;
    assign fill      = r_fill;
    assign running   = r_running;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Directed bench for linebuf_ctrl: priming, 480p and doubled reads, overflow,
// underflow, mode change and asynchronous reset, with hand-computed expectations.
module tb_linebuf_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        line_doubler;
    logic        starttrigger;
    logic        wr_line_done;
    logic        rd_line_start;
    logic        rd_active;
    logic [11:0] rdaddr;
    logic [1:0]  wr_slot;
    logic [2:0]  fill;
    logic        running;
    logic        overflow;
    logic        underflow;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clock = ~clock;

    linebuf_ctrl #(
        .LINE_WIDTH  (640),
        .PRIME_LINES (2)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .line_doubler  (line_doubler),
        .starttrigger  (starttrigger),
        .wr_line_done  (wr_line_done),
        .rd_line_start (rd_line_start),
        .rd_active     (rd_active),
        .rdaddr        (rdaddr),
        .wr_slot       (wr_slot),
        .fill          (fill),
        .running       (running),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Inputs are held for one rising edge, then pulses drop; outputs are sampled 1ns after the edge.
    task automatic applyStimulus(input logic st, input logic wd, input logic rs, input logic ra);
        starttrigger  = st;
        wr_line_done  = wd;
        rd_line_start = rs;
        rd_active     = ra;
        @(posedge clock);
        #1;
        starttrigger  = 1'b0;
        wr_line_done  = 1'b0;
        rd_line_start = 1'b0;
        rd_active     = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        line_doubler  = 1'b0;
        starttrigger  = 1'b0;
        wr_line_done  = 1'b0;
        rd_line_start = 1'b0;
        rd_active     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_rdaddr", 32'(rdaddr), 32'd0);
        checkOutput("rst_wr_slot", 32'(wr_slot), 32'd0);
        checkOutput("rst_fill", 32'(fill), 32'd0);
        checkOutput("rst_running", 32'(running), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_unf", 32'(underflow), 32'd0);
        reset_n = 1'b1;

        $display("[TB] 480p prime and read");
        applyStimulus(1, 0, 0, 0);
        checkOutput("p1_fill_start", 32'(fill), 32'd0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("p1_fill1", 32'(fill), 32'd1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("p1_fill2", 32'(fill), 32'd2);
        checkOutput("p1_run_not_yet", 32'(running), 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("p1_running", 32'(running), 32'd1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("p1_line0", 32'(rdaddr), 32'd0);
        repeat (3) applyStimulus(0, 0, 0, 1);
        checkOutput("p1_pix3", 32'(rdaddr), 32'd3);
        applyStimulus(0, 1, 1, 0);
        checkOutput("p1_line1", 32'(rdaddr), 32'd1024);
        checkOutput("p1_fill_l1", 32'(fill), 32'd2);
        checkOutput("p1_wr_l1", 32'(wr_slot), 32'd3);
        applyStimulus(0, 1, 1, 1);
        checkOutput("p1_line2", 32'(rdaddr), 32'd2048);
        checkOutput("p1_wr_wrap", 32'(wr_slot), 32'd0);
        applyStimulus(0, 1, 1, 0);
        checkOutput("p1_line3", 32'(rdaddr), 32'd3072);
        checkOutput("p1_fill_l3", 32'(fill), 32'd2);
        applyStimulus(0, 1, 0, 0);
        checkOutput("p1_fill3", 32'(fill), 32'd3);

        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("ar_fill", 32'(fill), 32'd0);
        checkOutput("ar_running", 32'(running), 32'd0);
        checkOutput("ar_rdaddr", 32'(rdaddr), 32'd0);
        checkOutput("ar_wr_slot", 32'(wr_slot), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        applyStimulus(0, 1, 1, 0);
        checkOutput("ar_idle_ignores", 32'(fill), 32'd0);

        $display("[TB] line doubler read");
        line_doubler = 1'b1;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("d_running", 32'(running), 32'd1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("d_pass0_slot0", 32'(rdaddr), 32'd0);
        repeat (5) applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("d_pass1_slot0", 32'(rdaddr), 32'd0);
        checkOutput("d_pass1_fill", 32'(fill), 32'd2);
        applyStimulus(0, 0, 1, 0);
        checkOutput("d_pass0_slot1", 32'(rdaddr), 32'd1024);
        checkOutput("d_fill1", 32'(fill), 32'd1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("d_pass1_slot1", 32'(rdaddr), 32'd1024);
        repeat (639) applyStimulus(0, 0, 0, 1);
        checkOutput("d_pix639", 32'(rdaddr), 32'd1663);
        repeat (61) applyStimulus(0, 0, 0, 1);
        checkOutput("d_pix_sat", 32'(rdaddr), 32'd1663);

        $display("[TB] mode change");
        line_doubler = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("mc_idle", 32'(running), 32'd0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("mc_fill0", 32'(fill), 32'd0);
        checkOutput("mc_wr0", 32'(wr_slot), 32'd0);
        checkOutput("mc_rdaddr0", 32'(rdaddr), 32'd0);

        $display("[TB] overflow");
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("ov_fill4", 32'(fill), 32'd4);
        checkOutput("ov_none_yet", 32'(overflow), 32'd0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("ov_pulse", 32'(overflow), 32'd1);
        checkOutput("ov_fill_hold", 32'(fill), 32'd4);
        checkOutput("ov_wr_hold", 32'(wr_slot), 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ov_one_cycle", 32'(overflow), 32'd0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 1, 0);
        checkOutput("ov_rel_none", 32'(overflow), 32'd0);
        checkOutput("ov_rel_fill", 32'(fill), 32'd4);
        checkOutput("ov_rel_wr", 32'(wr_slot), 32'd1);
        checkOutput("ov_rel_rd", 32'(rdaddr), 32'd1024);

        $display("[TB] underflow");
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("uf_fill1", 32'(fill), 32'd1);
        checkOutput("uf_none_yet", 32'(underflow), 32'd0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("uf_pulse", 32'(underflow), 32'd1);
        checkOutput("uf_fill0", 32'(fill), 32'd0);
        checkOutput("uf_rdaddr", 32'(rdaddr), 32'd1024);
        applyStimulus(0, 0, 0, 0);
        checkOutput("uf_one_cycle", 32'(underflow), 32'd0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("uf_refill", 32'(fill), 32'd1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("uf_resume_rd", 32'(rdaddr), 32'd1024);
        checkOutput("uf_resume_ok", 32'(underflow), 32'd0);
        checkOutput("uf_resume_fill", 32'(fill), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
